pixel_scheduler: RTL and testbench

Frame-level controller that sequences the ray unit. On a start pulse it latches the camera configuration and walks every pixel of an H_RES×V_RES frame in raster order. For each pixel it issues one screen coordinate pair into the ray unit, limiting outstanding rays with a credit counter. It buffers the returned hit/surface-point results in a FIFO and forwards them, in order, to the shading/frame-buffer stage over a valid/ready stream with frame and line markers.

---
 rtl/pixel_scheduler_pkg.sv | 27 ++
 rtl/pixel_scheduler_result_fifo.sv | 53 +++++
 rtl/pixel_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_pixel_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_scheduler_pkg.sv
// Shared types for the pixel scheduler: fixed-point scalar, 3-vector,
// per-pixel ray result and the frame sequencing state.
package pixel_scheduler_pkg;

  localparam int FP_W = 32;

  // Q16.16 two's-complement scalar
  typedef logic signed [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef struct packed {
    logic  hit;
    vec3_t point;
  } pix_res_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/pixel_scheduler_result_fifo.sv
// Synchronous result FIFO; entries live in flops, so a word written at
// cycle r is visible on out_data at r+1. Push and pop in one cycle keep count.
module result_fifo
  import pixel_scheduler_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = pix_res_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  T                           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output T                           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign do_pop    = out_valid & out_ready;
  // a full FIFO still accepts a write when the head leaves the same cycle
  assign do_push   = in_valid & (~full | do_pop);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/pixel_scheduler.sv
// Frame sequencer for the ray unit: raster-order issue with credit limiting,
// in-order result buffering and framed output. PIXEL_SCHED_STATS_EN adds counters.
module pixel_scheduler
  import pixel_scheduler_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  fp_t         x_start,
  input  fp_t         y_start,
  input  fp_t         x_step,
  input  fp_t         y_step,
  input  vec3_t       cam_forward,
  input  vec3_t       cam_right,
  input  vec3_t       cam_origin,
  input  logic        sdf_sel_in,
  output logic        busy,
  output logic        frame_done,
  output fp_t         ray_screen_x,
  output fp_t         ray_screen_y,
  output logic        ray_valid,
  output vec3_t       ray_forward,
  output vec3_t       ray_right,
  output vec3_t       ray_origin,
  output logic        ray_sdf_sel,
  input  logic        res_valid,
  input  logic        res_hit,
  input  vec3_t       res_point,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_hit,
  output vec3_t       pix_point,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        overflow
`ifdef PIXEL_SCHED_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_cycles
`endif
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT+1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES-1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES-1);

  sched_state_t  state, nxt_state;
  logic [CW-1:0] credits, fifo_count;
  logic [XW-1:0] ix, ox;
  logic [YW-1:0] iy, oy;
  fp_t           x_org, x_inc, y_inc;
  logic          start_ok, hs, last_out, fifo_full;
  pix_res_t      res_word, fifo_out;

  assign busy     = (state != S_IDLE);
  assign start_ok = (state == S_IDLE) & start;
  assign hs       = pix_valid & pix_ready;
  assign last_out = hs & (ox == X_LAST) & (oy == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    ray_valid = 1'b0;
    unique case (state)
      S_IDLE:  if (start) nxt_state = S_ISSUE;
      S_ISSUE: begin
        ray_valid = (credits < CW'(MAX_INFLIGHT));
        if (ray_valid && ix == X_LAST && iy == Y_LAST) nxt_state = S_DRAIN;
      end
      S_DRAIN: if (last_out) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Screen coordinates are accumulated; the line start is reloaded from x_org.
  always_ff @(posedge clk) begin
    if (rst) begin
      ray_screen_x <= '0;
      ray_screen_y <= '0;
      x_org        <= '0;
      x_inc        <= '0;
      y_inc        <= '0;
      ray_forward  <= '0;
      ray_right    <= '0;
      ray_origin   <= '0;
      ray_sdf_sel  <= 1'b0;
      ix           <= '0;
      iy           <= '0;
    end else if (start_ok) begin
      ray_screen_x <= x_start;
      ray_screen_y <= y_start;
      x_org        <= x_start;
      x_inc        <= x_step;
      y_inc        <= y_step;
      ray_forward  <= cam_forward;
      ray_right    <= cam_right;
      ray_origin   <= cam_origin;
      ray_sdf_sel  <= sdf_sel_in;
      ix           <= '0;
      iy           <= '0;
    end else if (ray_valid) begin
      if (ix == X_LAST) begin
        ix           <= '0;
        iy           <= (iy == Y_LAST) ? '0 : iy + 1'b1;
        ray_screen_x <= x_org;
        ray_screen_y <= ray_screen_y + y_inc;
      end else begin
        ix           <= ix + 1'b1;
        ray_screen_x <= ray_screen_x + x_inc;
      end
    end
  end

  // Credits count rays in the ray unit plus FIFO entries, bounding FIFO fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= '0;
      ox         <= '0;
      oy         <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case ({ray_valid, hs})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
      if (hs) begin
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
      frame_done <= (state == S_DRAIN) & last_out;
      if (res_valid && fifo_full) overflow <= 1'b1;
    end
  end

  assign res_word  = '{hit: res_hit, point: res_point};
  assign fifo_full = (fifo_count == CW'(MAX_INFLIGHT));

  result_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .T     (pix_res_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (res_valid),
    .in_data   (res_word),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign pix_hit   = pix_valid & fifo_out.hit;
  assign pix_point = fifo_out.point;
  assign pix_sof   = pix_valid & (ox == '0) & (oy == '0);
  assign pix_eol   = pix_valid & (ox == X_LAST);

`ifdef PIXEL_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_cycles <= '0;
    end else if (start_ok) begin
      stat_hits   <= '0;
      stat_cycles <= '0;
    end else begin
      if (busy)          stat_cycles <= stat_cycles + 1'b1;
      if (hs && pix_hit) stat_hits   <= stat_hits + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler: 4x2 frames with a 5-cycle ray model,
// plus a 1x1 instance. Expected pixels come from hand-written coordinate tables.
`timescale 1ns/1ps
module tb_pixel_scheduler;
  import pixel_scheduler_pkg::*;

  localparam int  H = 4, V = 2, MAXI = 4, LAT = 5;
  localparam fp_t ONE = 32'sh0001_0000;

  typedef struct packed {
    logic  hit;
    vec3_t point;
    logic  sof;
    logic  eol;
  } pix_obs_t;

  typedef struct packed {
    pix_obs_t obs;
    logic     last;
  } exp_t;

  // hand-computed frame: x = -2,-1,0,1 ; y = 1,0 ; hit = odd integer part of x
  int   xs_tab [H] = '{-2, -1, 0, 1};
  int   ys_tab [V] = '{1, 0};
  logic hit_tab[H] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic  clk, rst, start;
  fp_t   x_start, y_start, x_step, y_step;
  vec3_t cam_forward, cam_right, cam_origin;
  logic  sdf_sel_in;
  logic  busy, frame_done, ray_valid, ray_sdf_sel;
  fp_t   ray_screen_x, ray_screen_y;
  vec3_t ray_forward, ray_right, ray_origin;
  logic  res_valid, res_hit;
  vec3_t res_point;
  logic  pix_valid, pix_ready, pix_hit, pix_sof, pix_eol, overflow;
  vec3_t pix_point;

  logic  start1, busy1, frame_done1, rv1, rsdf1, res_valid1, pv1, ph1, sof1, eol1, ovf1;
  fp_t   rsx1, rsy1;
  vec3_t rf1, rr1, ro1, pp1, res_point1;
`ifdef PIXEL_SCHED_STATS_EN
  logic [31:0] stat_hits, stat_cycles, sh1, sc1;
`endif

  int checks = 0, failures = 0;
  int done_cnt = 0, issued_frame = 0, outst = 0, max_outst = 0;
  int ray1_cnt = 0, out1_cnt = 0, done1_cnt = 0;
  int rdy_mode = 1;
  logic     expect_done = 1'b0, prev_stall = 1'b0;
  pix_obs_t prev_obs;
  exp_t     exp_q[$];
  logic [63:0] iss_q[$];

  pixel_scheduler #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_start(x_start), .y_start(y_start), .x_step(x_step), .y_step(y_step),
    .cam_forward(cam_forward), .cam_right(cam_right), .cam_origin(cam_origin),
    .sdf_sel_in(sdf_sel_in), .busy(busy), .frame_done(frame_done),
    .ray_screen_x(ray_screen_x), .ray_screen_y(ray_screen_y), .ray_valid(ray_valid),
    .ray_forward(ray_forward), .ray_right(ray_right), .ray_origin(ray_origin),
    .ray_sdf_sel(ray_sdf_sel), .res_valid(res_valid), .res_hit(res_hit),
    .res_point(res_point), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_hit(pix_hit), .pix_point(pix_point), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .overflow(overflow)
`ifdef PIXEL_SCHED_STATS_EN
    , .stat_hits(stat_hits), .stat_cycles(stat_cycles)
`endif
  );

  pixel_scheduler #(.H_RES(1), .V_RES(1), .MAX_INFLIGHT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .x_start(3 * ONE), .y_start(ONE), .x_step(ONE), .y_step(ONE),
    .cam_forward('0), .cam_right('0), .cam_origin('0),
    .sdf_sel_in(1'b0), .busy(busy1), .frame_done(frame_done1),
    .ray_screen_x(rsx1), .ray_screen_y(rsy1), .ray_valid(rv1),
    .ray_forward(rf1), .ray_right(rr1), .ray_origin(ro1),
    .ray_sdf_sel(rsdf1), .res_valid(res_valid1), .res_hit(res_point1.x[16]),
    .res_point(res_point1), .pix_valid(pv1), .pix_ready(1'b1),
    .pix_hit(ph1), .pix_point(pp1), .pix_sof(sof1), .pix_eol(eol1),
    .overflow(ovf1)
`ifdef PIXEL_SCHED_STATS_EN
    , .stat_hits(sh1), .stat_cycles(sc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Ray unit model: fixed latency, echoes the coordinates it was given
  logic [LAT:0] vld_pipe;
  pix_res_t     dat_pipe [LAT+1];
  logic [2:0]   vld_pipe1;
  fp_t          x_pipe1  [3];

  always @(negedge clk) begin
    if (rst) begin
      vld_pipe  = '0;
      vld_pipe1 = '0;
    end else begin
      for (int i = LAT; i > 0; i--) begin
        vld_pipe[i] = vld_pipe[i-1];
        dat_pipe[i] = dat_pipe[i-1];
      end
      vld_pipe[0] = ray_valid;
      dat_pipe[0] = '{hit: ray_screen_x[16],
                      point: '{x: ray_screen_x, y: ray_screen_y, z: ray_forward.x}};
      for (int i = 2; i > 0; i--) begin
        vld_pipe1[i] = vld_pipe1[i-1];
        x_pipe1[i]   = x_pipe1[i-1];
      end
      vld_pipe1[0] = rv1;
      x_pipe1[0]   = rsx1;
    end
  end

  assign res_valid  = vld_pipe[LAT];
  assign res_hit    = dat_pipe[LAT].hit;
  assign res_point  = dat_pipe[LAT].point;
  assign res_valid1 = vld_pipe1[2];
  assign res_point1 = '{x: x_pipe1[2], y: ONE, z: ONE};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present expected=none", name);
  endtask

  // Monitor: pops the scoreboard on every ray issue and output handshake
  always @(negedge clk) begin
    pix_obs_t   cur;
    exp_t       e;
    logic [63:0] c;
    if (rst) begin
      exp_q.delete();
      iss_q.delete();
      outst       = 0;
      prev_stall  = 1'b0;
      expect_done = 1'b0;
    end else begin
      cur = '{hit: pix_hit, point: pix_point, sof: pix_sof, eol: pix_eol};
      if (prev_stall) chk("stall_hold", {pix_valid, cur}, {1'b1, prev_obs});
      if (expect_done) begin
        chk("frame_done_busy", {frame_done, busy}, 2'b10);
        expect_done = 1'b0;
      end else if (frame_done) begin
        flag_fail("frame_done_early");
      end
      if (frame_done) done_cnt++;
      if (ray_valid) begin
        issued_frame++;
        outst++;
        if (iss_q.size() == 0) flag_fail("ray_extra");
        else begin
          c = iss_q.pop_front();
          chk("ray_xy", {ray_screen_x, ray_screen_y}, c);
        end
      end
      if (pix_valid && pix_ready) begin
        outst--;
        if (exp_q.size() == 0) flag_fail("pix_extra");
        else begin
          e = exp_q.pop_front();
          chk("pix_out", cur, e.obs);
          if (e.last) expect_done = 1'b1;
        end
      end
      if (outst > max_outst) max_outst = outst;
      prev_stall = pix_valid & ~pix_ready;
      prev_obs   = cur;
      if (rv1) ray1_cnt++;
      if (pv1) begin
        out1_cnt++;
        chk("one_pixel", {ph1, sof1, eol1, pp1.x}, {1'b1, 1'b1, 1'b1, 3 * ONE});
      end
      if (frame_done1) done1_cnt++;
    end
  end

  task automatic start_frame(input fp_t cx, input int mode);
    exp_t e;
    fp_t  x, y;
    rdy_mode = mode;
    @(posedge clk); #1;
    for (int j = 0; j < V; j++)
      for (int i = 0; i < H; i++) begin
        x = fp_t'(xs_tab[i] * 65536);
        y = fp_t'(ys_tab[j] * 65536);
        iss_q.push_back({x, y});
        e.obs  = '{hit: hit_tab[i], point: '{x: x, y: y, z: cx}, sof: (i == 0 && j == 0), eol: (i == H-1)};
        e.last = (i == H-1 && j == V-1);
        exp_q.push_back(e);
      end
    x_start     = -2 * ONE;
    x_step      = ONE;
    y_start     = ONE;
    y_step      = -ONE;
    cam_forward = '{x: cx, y: cx, z: cx};
    sdf_sel_in  = 1'b1;
    issued_frame = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_to_busy", {busy, ray_valid}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_frame_done expected=frame_done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    x_start = '0; y_start = '0; x_step = '0; y_step = '0;
    cam_forward = '0; cam_right = '{x: ONE, y: ONE, z: ONE};
    cam_origin = '{x: 2 * ONE, y: 0, z: 0}; sdf_sel_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {busy, frame_done, ray_valid, pix_valid, overflow, ray_sdf_sel,
                        ray_screen_x, ray_screen_y, ray_forward, ray_right, ray_origin}, '0);
    chk("rst_outputs_1", {busy1, frame_done1, rv1, pv1, ovf1, rsdf1, rsy1, rf1, rr1, ro1}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // A: full rate, camera and x_start changed mid-frame
    start_frame(7 * ONE, 1);
    repeat (3) @(posedge clk);
    #1 cam_forward = '{x: 9 * ONE, y: 9 * ONE, z: 9 * ONE};
    x_start = 5 * ONE;
    wait_done(200);

    // B: output stalled, then random ready; a start while busy is ignored
    start_frame(8 * ONE, 0);
    repeat (3) @(posedge clk);
    #1 x_start = 5 * ONE; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_issue_cnt", issued_frame, MAXI);
    chk("bp_pix_valid", pix_valid, 1'b1);
    rdy_mode = 2;
    wait_done(400);

    // C: reset while issuing pixel 3, then D: clean frame afterwards
    start_frame(10 * ONE, 1);
    for (int n = 0; n < 50 && issued_frame < 3; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midframe_rst", {busy, frame_done, ray_valid, pix_valid, overflow, ray_sdf_sel,
                         ray_screen_x, ray_screen_y, ray_forward, ray_right, ray_origin}, '0);
    @(posedge clk); #1 rst = 1'b0;
    start_frame(11 * ONE, 1);
    wait_done(200);

    chk("max_outstanding", max_outst, MAXI);
    chk("overflow", overflow, 1'b0);
    chk("frame_count", done_cnt, 3);
    chk("queues_empty", {iss_q.size(), exp_q.size()}, '0);

    // 1x1 frame
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("one_ray_cnt", ray1_cnt, 1);
    chk("one_out_cnt", out1_cnt, 1);
    chk("one_done", {done1_cnt[7:0], busy1}, {8'd1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
